// File: rtl/microsequencer_if.sv
// microsequencer_if: control-word sequencing fields in, registered microaddress and status out.
interface microsequencer_if #(parameter int unsigned AW = 5);
    logic [1:0]    nssel;
    logic [AW-1:0] dbin;
    logic [2:0]    memcntl;
    logic [3:0]    opcode;
    logic [1:0]    mode;
    logic          zflag;
    logic          flag_we;
    logic          mem_ready;
    logic [AW-1:0] address;
    logic          stall;
    logic          illegal_op;
    modport master (
        output nssel, dbin, memcntl, opcode, mode, zflag, flag_we, mem_ready,
        input  address, stall, illegal_op
    );
    modport slave (
        input  nssel, dbin, memcntl, opcode, mode, zflag, flag_we, mem_ready,
        output address, stall, illegal_op
    );
endinterface

// File: rtl/microsequencer.sv
// microsequencer: next-microaddress generator with opcode/mode dispatch, conditional
// branch on a latched zero flag, memory-wait stall and a sticky illegal-instruction trap.
module microsequencer #(
    parameter int unsigned   AW           = 5,
    parameter logic [AW-1:0] RESET_VECTOR = '0,
    parameter logic [AW-1:0] TRAP_VECTOR  = '0
) (
    input logic            clock,
    input logic            reset,
    microsequencer_if.slave bus
);
    logic [AW-1:0] r_address;
    logic          r_zero;
    logic          r_illegal;
    logic [AW-1:0] w_next;
    logic          w_trap;
    logic          w_stall;

    assign w_stall        = (bus.memcntl != 3'b000) & ~bus.mem_ready;
    assign bus.stall      = w_stall;
    assign bus.address    = r_address;
    assign bus.illegal_op = r_illegal;

    always_comb begin
        w_trap = 1'b0;
        w_next = bus.dbin;
        case (bus.nssel)
            2'b01: case (bus.opcode)
                4'd0:  w_next = AW'(0);
                4'd1:  w_next = AW'(15);
                4'd2:  w_next = AW'(16);
                4'd3:  w_next = AW'(17);
                4'd4:  w_next = AW'(19);
                4'd5:  w_next = AW'(21);
                4'd6:  w_next = AW'(9);
                4'd7, 4'd8, 4'd9, 4'd10: begin
                    w_trap = bus.mode[1];
                    w_next = bus.mode[0] ? AW'(5) : AW'(1);
                end
                4'd11:   w_next = AW'(26);
                default: w_trap = 1'b1;
            endcase
            2'b10: case (bus.opcode)
                4'd7:    w_next = AW'(10);
                4'd8:    w_next = AW'(11);
                4'd9:    w_next = AW'(12);
                4'd10:   w_next = AW'(14);
                default: w_trap = 1'b1;
            endcase
            // Branch sees the pre-edge zero value even when flag_we is active this cycle.
            2'b11:   w_next = r_zero ? bus.dbin : bus.dbin + AW'(1);
            default: w_next = bus.dbin;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_address <= RESET_VECTOR;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (bus.flag_we) r_zero <= bus.zflag;
            if (!w_stall) begin
                r_address <= w_trap ? TRAP_VECTOR : w_next;
                if (w_trap) r_illegal <= 1'b1;
            end
        end
    end
endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-address generator that sits directly upstream of the 32-entry microcode control store.
- Each cycle it takes the sequencing fields of the current control word (nssel, dbin, memcntl), plus the IR opcode/mode fields and the ALU zero flag.
- It produces the registered 5-bit microaddress that the control store samples on the next clock edge.
- It also implements opcode/mode dispatch, conditional micro-branching, memory-wait stalling and an illegal-instruction trap.

Parameters:
- AW, 5, microaddress width; matches control store depth of 32.
- RESET_VECTOR, 5'd0, address loaded on reset (start0).
- TRAP_VECTOR, 5'd0, address taken on illegal opcode or mode.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- nssel  input  2  next-state select field of the current control word.
- dbin  input  AW  direct/base next-address field of the current control word.
- memcntl  input  3  memory-control field of the current control word; 000 means no memory access.
- opcode  input  4  instruction opcode from the IR.
- mode  input  2  addressing-mode field from the IR.
- zflag  input  1  ALU zero result.
- flag_we  input  1  latches zflag into the internal zero register.
- mem_ready  input  1  memory handshake; 1 means the current access completes this cycle.
- address  output  AW  registered microaddress driven to the control store.
- stall  output  1  combinational; high when the sequencer is holding due to memory wait.
- illegal_op  output  1  sticky registered flag, set on trap.

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high.
- Reset values:
  - address = RESET_VECTOR.
  - zero register = 0.
  - illegal_op = 0.
  - stall follows its combinational equation.
- Reset asserted mid-operation forces these values immediately, regardless of any stall.
- Latency: fields presented in cycle n determine address after posedge n. The control store registers that address, so the control word is valid in cycle n+1.
- Stall:
  - stall = (memcntl != 000) & ~mem_ready.
  - While stall is high, address holds its value, so the same control word is refetched.
  - No dispatch, trap or illegal_op update happens while stalled.
  - The zero register still updates on flag_we.
- Next address when not stalled:
  - nssel=00 (direct): next address = dbin.
  - nssel=01 (instruction dispatch on opcode):
    - 0 -> 0
    - 1 -> 15
    - 2 -> 16
    - 3 -> 17
    - 4 -> 19
    - 5 -> 21
    - 6 -> 9
    - 11 -> 26
    - 7, 8, 9, 10: mode 00 -> 1, mode 01 -> 5, mode 1x -> trap.
    - 12 to 15 -> trap.
    - dbin is ignored.
  - nssel=10 (operation dispatch after address calculation):
    - opcode 7 -> 10
    - opcode 8 -> 11
    - opcode 9 -> 12
    - opcode 10 -> 14
    - any other opcode -> trap.
    - dbin is ignored.
  - nssel=11 (conditional): next address = zero register ? dbin : dbin+1. The increment is modulo 2^AW, so 31+1 wraps to 0.
- Zero register:
  - Loads zflag on a posedge when flag_we=1.
  - If flag_we and nssel=11 occur in the same cycle, the branch uses the old (pre-edge) value.
- Trap:
  - next address = TRAP_VECTOR and illegal_op <= 1.
  - illegal_op stays set until reset; a later legal dispatch does not clear it.
- Purely synchronous datapath apart from reset; no combinational path from inputs to address.

Test Plan:
- Reset: assert reset mid-stream with address=17 -> address=0 and illegal_op=0 immediately, without waiting for a clock edge; after release, nssel=00, dbin=5'd23 -> address=23 after one edge.
- Dispatch: nssel=01 with opcode=3 -> 17; opcode=7, mode=01 -> 5; then nssel=10, opcode=9 -> 12. Check opcode 0..11 against the full table.
- Conditional:
  - flag_we=1, zflag=1, then nssel=11, dbin=6 -> 6.
  - zflag latched 0 -> 7.
  - dbin=31 with zero=0 -> 0 (wrap).
  - Same-cycle flag_we=1, zflag=0 with old zero=1 -> branch takes dbin.
- Stall: address=1, memcntl=001, mem_ready=0 for 3 cycles -> stall=1 and address stays 1; mem_ready=1 with nssel=00, dbin=2 -> address=2 next edge.
- Trap: nssel=01, opcode=13 -> address=TRAP_VECTOR(0), illegal_op=1; opcode=7, mode=10 also traps; illegal_op stays 1 after later legal dispatches until reset.
- Stall vs trap: illegal opcode presented with stall=1 -> no trap and illegal_op stays 0 until mem_ready=1.
